// File: rtl/vga_rect_fill.sv
// vga_rect_fill: Avalon-MM master that paints a constant-brightness rectangle
// into the VGA adapter, one pixel write per point, programmed by the CPU
// through a small slave register file.
module vga_rect_fill #(
  parameter int          SCREEN_W = 160,
  parameter int          SCREEN_H = 120,
  parameter logic [31:0] PIX_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [8:0] SCREEN_W9 = 9'(SCREEN_W);
  localparam logic [7:0] SCREEN_H8 = 8'(SCREEN_H);

  state_t      state_q, state_d;
  logic [7:0]  x0_q, w_q, b_q, col_q;
  logic [6:0]  y0_q, h_q, row_q;
  logic [14:0] pixCount_q;
  logic        done_q, fillActive_q, abortPend_q;
  logic [31:0] readData_q;

  logic        ctrlWr, startReq, clearReq, abortReq;
  logic [8:0]  pixX;
  logic [7:0]  pixY;
  logic        inBounds, accepted, stepOk, lastCol, lastPoint, sizeOk;

  // Register-file decode and the current pixel position / bus handshake.
  always_comb begin
    ctrlWr    = slave_write && (slave_address == 3'd0);
    startReq  = ctrlWr && slave_writedata[0];
    clearReq  = ctrlWr && slave_writedata[1];
    abortReq  = ctrlWr && slave_writedata[2];
    sizeOk    = (w_q != 8'd0) && (h_q != 7'd0);
    pixX      = {1'b0, x0_q} + {1'b0, col_q};
    pixY      = {1'b0, y0_q} + {1'b0, row_q};
    inBounds  = (pixX < SCREEN_W9) && (pixY < SCREEN_H8);
    master_write = (state_q == RUN) && inBounds;
    master_writedata = master_write ? {9'b0, pixY[6:0], pixX[7:0], b_q} : 32'd0;
    master_address = PIX_ADDR;
    accepted  = master_write && !master_waitrequest;
    // A clipped point costs exactly one cycle; a visible one waits for the slave.
    stepOk    = inBounds ? !master_waitrequest : 1'b1;
    lastCol   = (col_q == w_q - 8'd1);
    lastPoint = lastCol && (row_q == h_q - 7'd1);
  end

  // Next-state logic; an abort never abandons a write the slave is still stalling.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (startReq) state_d = sizeOk ? RUN : DONE;
      end
      RUN: begin
        if ((abortReq || abortPend_q) && !(master_write && master_waitrequest))
          state_d = IDLE;
        else if (stepOk && lastPoint)
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus the fill bookkeeping that follows it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      col_q        <= 8'd0;
      row_q        <= 7'd0;
      pixCount_q   <= 15'd0;
      done_q       <= 1'b0;
      fillActive_q <= 1'b0;
      abortPend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      abortPend_q <= (state_q == RUN) && (state_d == RUN) && (abortReq || abortPend_q);
      if (state_q == IDLE) begin
        fillActive_q <= (state_d == RUN);
      end else if (state_d == IDLE) begin
        fillActive_q <= 1'b0;
      end
      if (state_q == IDLE && startReq) begin
        col_q      <= 8'd0;
        row_q      <= 7'd0;
        pixCount_q <= 15'd0;
      end else begin
        if (accepted) pixCount_q <= pixCount_q + 15'd1;
        if (state_q == RUN && stepOk && !lastPoint) begin
          if (lastCol) begin
            col_q <= 8'd0;
            row_q <= row_q + 7'd1;
          end else begin
            col_q <= col_q + 8'd1;
          end
        end
      end
      if (state_q == IDLE && startReq) done_q <= 1'b0;
      else if (state_q == DONE)        done_q <= 1'b1;
      else if (clearReq)               done_q <= 1'b0;
    end
  end

  // Programmed geometry and brightness; frozen while a fill is in progress,
  // so the engine reads them directly instead of keeping a second copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_q <= 8'd0;
      y0_q <= 7'd0;
      w_q  <= 8'd0;
      h_q  <= 7'd0;
      b_q  <= 8'd0;
    end else if (slave_write && !fillActive_q) begin
      case (slave_address)
        3'd1: begin
          x0_q <= slave_writedata[7:0];
          y0_q <= slave_writedata[14:8];
        end
        3'd2: begin
          w_q <= slave_writedata[7:0];
          h_q <= slave_writedata[14:8];
        end
        3'd3: b_q <= slave_writedata[7:0];
        default: ;
      endcase
    end
  end

  // Registered read port: data appears the cycle after slave_read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readData_q <= 32'd0;
    end else if (slave_read) begin
      case (slave_address)
        3'd0:    readData_q <= {30'd0, done_q, fillActive_q};
        3'd1:    readData_q <= {17'd0, y0_q, x0_q};
        3'd2:    readData_q <= {17'd0, h_q, w_q};
        3'd3:    readData_q <= {24'd0, b_q};
        3'd4:    readData_q <= {17'd0, pixCount_q};
        default: readData_q <= 32'd0;
      endcase
    end
  end

  assign slave_readdata = readData_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// tb_vga_rect_fill: directed scenarios; expected pixel words and register
// reads go into queues that independent monitors pop and compare.
module tb_vga_rect_fill;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  slave_address = 3'd0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = 32'd0;
  logic        master_waitrequest = 1'b0;
  logic [31:0] master_address;
  logic        master_write;
  logic [31:0] master_writedata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int startCyc = 0;
  int firstAccCyc = -1;
  int lastAccCyc = -1;
  int stallCount = 0;
  logic        rdValid = 1'b0;
  logic        prevStalled = 1'b0;
  logic [31:0] prevData = 32'd0;
  logic [31:0] pixQ[$];
  logic [31:0] rdQ[$];

  vga_rect_fill dut (
    .clk(clk), .reset(reset),
    .slave_address(slave_address), .slave_read(slave_read),
    .slave_readdata(slave_readdata), .slave_write(slave_write),
    .slave_writedata(slave_writedata),
    .master_waitrequest(master_waitrequest), .master_address(master_address),
    .master_write(master_write), .master_writedata(master_writedata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rdValid <= slave_read;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Pixel monitor: every accepted write must match the queue head.
  always @(negedge clk) begin
    if (reset) begin
      prevStalled = 1'b0;
    end else begin
      if (prevStalled) begin
        check("held write", {31'd0, master_write}, 32'd1);
        check("held data", master_writedata, prevData);
      end
      if (master_write) begin
        check("master_address", master_address, 32'd0);
        if (master_waitrequest) begin
          stallCount++;
        end else begin
          if (firstAccCyc < 0) firstAccCyc = cyc;
          lastAccCyc = cyc;
          if (pixQ.size() == 0) check("unexpected pixel", master_writedata, 32'hFFFFFFFF);
          else check("pixel", master_writedata, pixQ.pop_front());
        end
      end
      prevStalled = master_write && master_waitrequest;
      prevData = master_writedata;
    end
  end

  // Read monitor: readdata is compared the cycle after the strobe.
  always @(negedge clk) begin
    if (rdValid && !reset) begin
      if (rdQ.size() == 0) check("unexpected read", slave_readdata, 32'hFFFFFFFF);
      else check("readdata", slave_readdata, rdQ.pop_front());
    end
  end

  task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
    slave_address   = addr;
    slave_writedata = data;
    slave_write     = 1'b1;
    @(posedge clk); #1;
    slave_write = 1'b0;
  endtask

  task automatic checkOutput(input logic [2:0] addr, input logic [31:0] expected);
    rdQ.push_back(expected);
    slave_address = addr;
    slave_read    = 1'b1;
    @(posedge clk); #1;
    slave_read = 1'b0;
  endtask

  task automatic startFill();
    applyStimulus(3'd0, 32'd1);
    startCyc = cyc;
    firstAccCyc = -1;
    lastAccCyc = -1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Reset state of every register and of the master port.
    check("reset master_write", {31'd0, master_write}, 32'd0);
    check("reset master_address", master_address, 32'd0);
    for (int a = 0; a < 6; a++) checkOutput(3'(a), 32'd0);

    // Plain 2x2 fill, slave never stalls.
    applyStimulus(3'd1, 32'h0000140A);
    applyStimulus(3'd2, 32'h00000202);
    applyStimulus(3'd3, 32'h00000080);
    checkOutput(3'd1, 32'h0000140A);
    pixQ.push_back(32'h00140A80); pixQ.push_back(32'h00140B80);
    pixQ.push_back(32'h00150A80); pixQ.push_back(32'h00150B80);
    startFill();
    repeat (8) @(posedge clk); #1;
    check("2x2 first write latency", 32'(firstAccCyc), 32'(startCyc));
    check("2x2 back-to-back", 32'(lastAccCyc), 32'(startCyc + 3));
    checkOutput(3'd0, 32'd2);
    checkOutput(3'd4, 32'd4);

    // Same fill with a 3-cycle stall on the first pixel.
    pixQ.push_back(32'h00140A80); pixQ.push_back(32'h00140B80);
    pixQ.push_back(32'h00150A80); pixQ.push_back(32'h00150B80);
    stallCount = 0;
    master_waitrequest = 1'b1;
    startFill();
    repeat (3) @(posedge clk); #1;
    master_waitrequest = 1'b0;
    repeat (8) @(posedge clk); #1;
    check("stall cycles", 32'(stallCount), 32'd3);
    check("stalled last write", 32'(lastAccCyc), 32'(startCyc + 6));
    checkOutput(3'd4, 32'd4);

    // Clipping at the bottom-right corner.
    applyStimulus(3'd1, 32'h0000779E);
    applyStimulus(3'd2, 32'h00000204);
    pixQ.push_back(32'h00779E80); pixQ.push_back(32'h00779F80);
    startFill();
    repeat (8) @(posedge clk); #1;
    checkOutput(3'd0, 32'd1);
    checkOutput(3'd0, 32'd2);
    checkOutput(3'd4, 32'd2);
    check("clip queue drained", 32'(pixQ.size()), 32'd0);

    // Zero-width fill: done without any write and without busy.
    applyStimulus(3'd2, 32'h00000500);
    startFill();
    checkOutput(3'd0, 32'd0);
    checkOutput(3'd0, 32'd2);
    checkOutput(3'd4, 32'd0);
    applyStimulus(3'd0, 32'd2);
    checkOutput(3'd0, 32'd0);

    // Abort while the third pixel of a 10x10 fill is stalled.
    applyStimulus(3'd1, 32'h00000000);
    applyStimulus(3'd2, 32'h00000A0A);
    applyStimulus(3'd3, 32'h00000055);
    pixQ.push_back(32'h00000055); pixQ.push_back(32'h00000155);
    pixQ.push_back(32'h00000255);
    startFill();
    repeat (2) @(posedge clk); #1;
    master_waitrequest = 1'b1;
    applyStimulus(3'd1, 32'h00000505);
    applyStimulus(3'd0, 32'd4);
    repeat (2) @(posedge clk); #1;
    check("abort holds write", {31'd0, master_write}, 32'd1);
    master_waitrequest = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("abort stops writes", {31'd0, master_write}, 32'd0);
    checkOutput(3'd0, 32'd0);
    checkOutput(3'd4, 32'd3);
    checkOutput(3'd1, 32'd0);

    // Reset in the middle of a fill drops the write at once.
    pixQ.push_back(32'h00000055); pixQ.push_back(32'h00000155);
    pixQ.push_back(32'h00000255);
    startFill();
    repeat (3) @(posedge clk);
    #1 check("write before reset", {31'd0, master_write}, 32'd1);
    #1 reset = 1'b1;
    #1 check("reset drops write", {31'd0, master_write}, 32'd0);
    check("reset clears data", master_writedata, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checkOutput(3'd0, 32'd0);
    checkOutput(3'd4, 32'd0);
    checkOutput(3'd3, 32'd0);
    repeat (3) @(posedge clk); #1;

    check("pixel queue empty", 32'(pixQ.size()), 32'd0);
    check("read queue empty", 32'(rdQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
